ib_mul_8x8_s0_l4: RTL and testbench
===================================

IB_MUL_8X8_S0_L4 -- requirements
Module: ib_mul_8x8_s0_l4

Interface
- REQ-001 Parameters: none; the operand widths of 8 and 8 and the product width of 16 SHALL be fixed.
- REQ-002 i_clk, input, 1: sole clock; all state SHALL update on its rising edge.
- REQ-003 i_nrst, input, 1: reset, synchronous, active-high (asserted when i_nrst=1), sampled on rising i_clk.
- REQ-004 i_start, input, 1: start request, sampled on rising i_clk.
- REQ-005 i_a, input, 8: unsigned multiplicand.
- REQ-006 i_b, input, 8: unsigned multiplier.
- REQ-007 o_c, output, 16: unsigned product a*b, registered.
- REQ-008 o_done, output, 1: result-valid flag, registered.

Function
- REQ-009 States: IDLE, BUSY (step counter 0..3), DONE.
- REQ-010 On the edge where i_start=1 and reset is not asserted, the block SHALL:
  - capture i_a and i_b;
  - clear the accumulator;
  - clear o_done;
  - enter BUSY at step 0.
- REQ-011 BUSY SHALL be a radix-4 shift-add: each edge adds (a * 2-bit digit of b) << (2*step), least-significant digit first, over exactly 4 edges.
- REQ-012 On the 4th edge after the start edge, o_c SHALL equal the full 16-bit product and o_done SHALL rise to 1 (latency 4 cycles); state then goes to DONE.
- REQ-013 Arithmetic: unsigned, no truncation, no overflow. Maximum result 255*255 = 65025 (0xFE01).
- REQ-014 o_c SHALL hold its last completed product until the next completion or reset; intermediate accumulator values SHALL NOT appear on o_c.
- REQ-015 In DONE, o_done SHALL stay 1 until the edge that accepts the next i_start or reset.
- REQ-016 i_start=1 while BUSY SHALL abort the current operation and restart with the newly captured operands; o_done stays 0.
- REQ-017 i_a and i_b SHALL be ignored on every edge except a start edge; changing them mid-operation SHALL NOT affect the result.
- REQ-018 i_start held high continuously SHALL restart every edge and never complete.

Reset
- REQ-019 Reset asserted on an edge: o_c=0, o_done=0, accumulator=0, captured operands=0, state IDLE.
- REQ-020 Reset SHALL take priority over i_start.
- REQ-021 Reset mid-operation SHALL abort the operation with no o_done pulse.

Configuration
- REQ-022 Macro IB_MUL_DONE_PULSE_EN.
  - Defined: o_done SHALL be high for exactly one cycle (the completion edge), then return to 0; o_c still holds.
  - Undefined (default): sticky o_done per REQ-015.
  - Latency and o_c behaviour SHALL be identical in both builds.

Verification
- REQ-023 Reset, then a=3, b=5, one-cycle start -> o_done=1 exactly 4 edges after the start edge, o_c=15; o_done=0 on the first 3 edges.
- REQ-024 a=255, b=255 -> o_c=0xFE01; a=0, b=200 -> o_c=0; a=200, b=1 -> o_c=200.
- REQ-025 Exhaustive sweep of all 65536 (a,b) pairs, each as start pulse then wait for o_done -> o_c === a*b every time; sticky o_done SHALL be low on the edge after each start.
- REQ-026 Start a=10, b=10, assert reset at step 2 -> o_c=0, o_done=0, no completion; a subsequent a=7, b=9 start -> o_c=63.
- REQ-027 Start a=12, b=12, restart at step 1 with a=2, b=3 -> single completion 4 edges after the restart, o_c=6.
- REQ-028 With IB_MUL_DONE_PULSE_EN defined, a=6, b=7 -> o_done high for one cycle, o_c=42 held afterwards.

Source files
------------

// File: rtl/ib_mul_8x8_s0_l4.sv
// Unsigned 8x8 radix-4 shift-add multiplier, four BUSY cycles per product.
// Build option IB_MUL_DONE_PULSE_EN turns o_done into a one-cycle pulse (default: sticky until next start/reset).
module ib_mul_8x8_s0_l4 (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_start,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_c,
    output logic        o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  step_r;
    logic [1:0]  step_nxt_s;
    logic [7:0]  a_r;
    logic [7:0]  a_nxt_s;
    logic [7:0]  b_r;
    logic [7:0]  b_nxt_s;
    logic [15:0] acc_r;
    logic [15:0] acc_nxt_s;
    logic [15:0] c_r;
    logic [15:0] c_nxt_s;
    logic        done_r;
    logic        done_nxt_s;
    logic [1:0]  digit_s;
    logic [15:0] term_s;
    logic [15:0] sum_s;

    // a * digit, placed at the weight of the current radix-4 digit
    function automatic logic [15:0] radix4_term(input logic [7:0] a,
                                                input logic [1:0] digit,
                                                input logic [1:0] step);
        logic [9:0] mult;
        case (digit)
            2'd0:    mult = 10'd0;
            2'd1:    mult = {2'd0, a};
            2'd2:    mult = {1'b0, a, 1'b0};
            2'd3:    mult = {2'd0, a} + {1'b0, a, 1'b0};
            default: mult = 10'd0;
        endcase
        return {6'd0, mult} << {step, 1'b0};
    endfunction

    // Current digit of the captured multiplier and the running sum
    always_comb begin
        digit_s = b_r[{step_r, 1'b0} +: 2];
        term_s  = radix4_term(a_r, digit_s, step_r);
        sum_s   = acc_r + term_s;
    end

    // Next-state and datapath updates; a start request overrides any state
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = step_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        acc_nxt_s   = acc_r;
        c_nxt_s     = c_r;
        done_nxt_s  = done_r;
        if (i_start) begin
            a_nxt_s     = i_a;
            b_nxt_s     = i_b;
            acc_nxt_s   = 16'd0;
            done_nxt_s  = 1'b0;
            step_nxt_s  = 2'd0;
            state_nxt_s = ST_BUSY;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_BUSY: begin
                    acc_nxt_s = sum_s;
                    if (step_r == 2'd3) begin
                        c_nxt_s     = sum_s;
                        done_nxt_s  = 1'b1;
                        step_nxt_s  = 2'd0;
                        state_nxt_s = ST_DONE;
                    end else begin
                        step_nxt_s  = step_r + 2'd1;
                    end
                end
                ST_DONE: begin
`ifdef IB_MUL_DONE_PULSE_EN
                    done_nxt_s = 1'b0;
`else
                    done_nxt_s = 1'b1;
`endif
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    step_nxt_s  = 2'd0;
                    done_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_nrst) begin
            state_r <= ST_IDLE;
            step_r  <= 2'd0;
            a_r     <= 8'd0;
            b_r     <= 8'd0;
            acc_r   <= 16'd0;
            c_r     <= 16'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            step_r  <= step_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            acc_r   <= acc_nxt_s;
            c_r     <= c_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign o_c    = c_r;
    assign o_done = done_r;

endmodule

// File: tb/tb_ib_mul_8x8_s0_l4.sv
// Self-checking bench for ib_mul_8x8_s0_l4: vector table, corner sequences, strided operand sweep.
module tb_ib_mul_8x8_s0_l4;

    logic        i_clk;
    logic        i_nrst;
    logic        i_start;
    logic [7:0]  i_a;
    logic [7:0]  i_b;
    logic [15:0] o_c;
    logic        o_done;

    int checks;
    int failures;

`ifdef IB_MUL_DONE_PULSE_EN
    localparam logic DONE_AFTER = 1'b0;
`else
    localparam logic DONE_AFTER = 1'b1;
`endif

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] c;
    } vec_t;

    vec_t vecs[8];

    ib_mul_8x8_s0_l4 dut (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_c     (o_c),
        .o_done  (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Start pulse with a,b; scramble operands afterwards; check latency, result and hold
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                          input string name);
        i_start = 1'b1;
        i_a     = a;
        i_b     = b;
        tick();
        chk({name, "_done_after_start"}, {31'd0, o_done}, 32'd0);
        i_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            i_a = 8'($urandom_range(0, 255));
            i_b = 8'($urandom_range(0, 255));
            tick();
            chk({name, "_done_early"}, {31'd0, o_done}, 32'd0);
        end
        tick();
        chk({name, "_done"}, {31'd0, o_done}, 32'd1);
        chk({name, "_c"}, {16'd0, o_c}, {16'd0, exp});
        tick();
        chk({name, "_done_after"}, {31'd0, o_done}, {31'd0, DONE_AFTER});
        chk({name, "_c_hold"}, {16'd0, o_c}, {16'd0, exp});
    endtask

    initial begin
        logic [15:0] prod;
        checks   = 0;
        failures = 0;
        i_nrst   = 1'b1;
        i_start  = 1'b0;
        i_a      = 8'd0;
        i_b      = 8'd0;

        vecs[0] = '{a: 8'd3,   b: 8'd5,   c: 16'd15};
        vecs[1] = '{a: 8'd255, b: 8'd255, c: 16'hFE01};
        vecs[2] = '{a: 8'd0,   b: 8'd200, c: 16'd0};
        vecs[3] = '{a: 8'd200, b: 8'd1,   c: 16'd200};
        vecs[4] = '{a: 8'd1,   b: 8'd255, c: 16'd255};
        vecs[5] = '{a: 8'd128, b: 8'd2,   c: 16'd256};
        vecs[6] = '{a: 8'd6,   b: 8'd7,   c: 16'd42};
        vecs[7] = '{a: 8'd170, b: 8'd85,  c: 16'd14450};

        // Reset, with a start request proving reset priority
        tick();
        i_start = 1'b1;
        i_a     = 8'd9;
        i_b     = 8'd9;
        tick();
        i_start = 1'b0;
        chk("reset_c", {16'd0, o_c}, 32'd0);
        chk("reset_done", {31'd0, o_done}, 32'd0);
        i_nrst = 1'b0;
        tick();
        chk("idle_done", {31'd0, o_done}, 32'd0);
        chk("idle_c", {16'd0, o_c}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, $sformatf("vec%0d", i));
        end

        // Reset at step 2 aborts with no completion (o_c currently holds 14450)
        i_start = 1'b1;
        i_a     = 8'd10;
        i_b     = 8'd10;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        i_nrst = 1'b1;
        tick();
        i_nrst = 1'b0;
        chk("abort_c", {16'd0, o_c}, 32'd0);
        chk("abort_done", {31'd0, o_done}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_no_done", {31'd0, o_done}, 32'd0);
            chk("abort_c_zero", {16'd0, o_c}, 32'd0);
        end
        run_op(8'd7, 8'd9, 16'd63, "after_abort");

        // Restart at step 1 with new operands
        i_start = 1'b1;
        i_a     = 8'd12;
        i_b     = 8'd12;
        tick();
        i_start = 1'b0;
        tick();
        run_op(8'd2, 8'd3, 16'd6, "restart");

        // Start held high never completes; result uses the last captured operands
        for (int k = 0; k < 10; k++) begin
            i_start = 1'b1;
            i_a     = 8'(k + 20);
            i_b     = 8'(k + 3);
            tick();
            chk("held_start_done", {31'd0, o_done}, 32'd0);
        end
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("held_release_early", {31'd0, o_done}, 32'd0);
        end
        tick();
        chk("held_release_done", {31'd0, o_done}, 32'd1);
        chk("held_release_c", {16'd0, o_c}, 32'd348);
        tick();

        // Strided sweep including both operand extremes
        for (int a = 0; a <= 255; a += 15) begin
            for (int b = 0; b <= 255; b += 15) begin
                prod = 16'(a * b);
                run_op(8'(a), 8'(b), prod, $sformatf("sweep_%0d_%0d", a, b));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
